// File: rtl/mod_inverse_if.sv
// Start/done handshake between a requester and the modular-inverse engine.
// The master drives the operands and start. The slave returns the result.
interface mod_inverse_if #(
  parameter int WIDTH = 512
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] m_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] inv_out;
  logic             inv_ok;

  modport master (
    output start, a_in, m_in,
    input  busy, done, inv_out, inv_ok
  );

  modport slave (
    input  start, a_in, m_in,
    output busy, done, inv_out, inv_ok
  );
endinterface

// File: rtl/mod_inverse.sv
// Sequential modular inverse, inv_out = a_in^-1 mod m_in.
// Uses the extended binary GCD and performs one shift/subtract step per clock.
module mod_inverse #(
  parameter int WIDTH = 512
) (
  input  logic          aclk,
  input  logic          aresetn,
  mod_inverse_if.slave  bus
);

  localparam int SW = WIDTH + 2;
  typedef logic signed [SW-1:0] coef_t;
  typedef enum logic [2:0] {IDLE, CHECK, RUN, NORM, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x, y, u, v;
  coef_t            ca, cb, cc, cd;
  coef_t            x_s, y_s;
  logic [WIDTH-1:0] res_val;
  logic             res_ok;
  logic             busy_r, done_r, ok_r;
  logic [WIDTH-1:0] out_r;

  assign x_s = {2'b00, x};
  assign y_s = {2'b00, y};

  // Add at one extra bit so the sum cannot overflow, then halve arithmetically.
  function automatic coef_t halve(input coef_t val, input coef_t addend);
    logic signed [SW:0] s;
    s = {val[SW-1], val} + {addend[SW-1], addend};
    s = s >>> 1;
    return s[SW-1:0];
  endfunction

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      out_r  <= '0;
      ok_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x      <= bus.a_in;
            y      <= bus.m_in;
            u      <= bus.a_in;
            v      <= bus.m_in;
            ca     <= coef_t'(1);
            cb     <= '0;
            cc     <= '0;
            cd     <= coef_t'(1);
            busy_r <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (x == '0 || y < WIDTH'(2) || (!x[0] && !y[0])) begin
            res_val <= '0;
            res_ok  <= 1'b0;
            state   <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          // Invariants: ca*x + cb*y == u and cc*x + cd*y == v.
          if (u == '0) begin
            state <= NORM;
          end else if (!u[0]) begin
            u <= u >> 1;
            if (!ca[0] && !cb[0]) begin
              ca <= halve(ca, '0);
              cb <= halve(cb, '0);
            end else begin
              ca <= halve(ca, y_s);
              cb <= halve(cb, -x_s);
            end
          end else if (!v[0]) begin
            v <= v >> 1;
            if (!cc[0] && !cd[0]) begin
              cc <= halve(cc, '0);
              cd <= halve(cd, '0);
            end else begin
              cc <= halve(cc, y_s);
              cd <= halve(cd, -x_s);
            end
          end else if (u >= v) begin
            u  <= u - v;
            ca <= ca - cc;
            cb <= cb - cd;
          end else begin
            v  <= v - u;
            cc <= cc - ca;
            cd <= cd - cb;
          end
        end
        NORM: begin
          // v holds the gcd. cc needs reduction into [0, y-1].
          if (v != WIDTH'(1)) begin
            res_val <= '0;
            res_ok  <= 1'b0;
            state   <= DONE;
          end else if (cc[SW-1]) begin
            cc <= cc + y_s;
          end else if (cc >= y_s) begin
            cc <= cc - y_s;
          end else begin
            res_val <= cc[WIDTH-1:0];
            res_ok  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          out_r  <= res_val;
          ok_r   <= res_ok;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.inv_out = out_r;
  assign bus.inv_ok  = ok_r;

endmodule

// File: tb/tb_mod_inverse.sv
// Directed-vector bench for mod_inverse with hand-computed inverses.
module tb_mod_inverse;
  localparam int W      = 16;
  localparam int MAXLAT = 4 * W + 8;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;
  int   cnt;

  mod_inverse_if #(.WIDTH(W)) bus ();
  mod_inverse #(.WIDTH(W)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request; optionally pulse a second start (2, 5) at wait cycle inj.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] m,
                        input int inj, output int lat_o);
    @(negedge aclk);
    check_eq({tag, "_prev_done_low"}, bus.done, 1'b0);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.m_in  = m;
    @(negedge aclk);
    bus.start = 1'b0;
    check_eq({tag, "_busy"}, bus.busy, 1'b1);
    lat_o = 0;
    for (int k = 1; k <= MAXLAT; k++) begin
      @(negedge aclk);
      if (k == inj) begin
        bus.start = 1'b1;
        bus.a_in  = W'(2);
        bus.m_in  = W'(5);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat_o = k;
        break;
      end
    end
    bus.start = 1'b0;
    check_eq({tag, "_done_seen"}, bus.done, 1'b1);
    check_eq({tag, "_busy_at_done"}, bus.busy, 1'b0);
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      if (bus.done) c++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.m_in  = '0;
    repeat (2) @(negedge aclk);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_done", bus.done, 1'b0);
    check_eq("rst_out", bus.inv_out, 0);
    check_eq("rst_ok", bus.inv_ok, 1'b0);
    aresetn = 1'b1;

    run_op("rsa", 17, 3120, 0, lat);
    check_eq("rsa_out", bus.inv_out, 2753);
    check_eq("rsa_ok", bus.inv_ok, 1'b1);

    run_op("inv3", 3, 11, 0, lat);
    check_eq("inv3_out", bus.inv_out, 4);
    check_eq("inv3_ok", bus.inv_ok, 1'b1);

    run_op("inv10", 10, 11, 0, lat);
    check_eq("inv10_out", bus.inv_out, 10);
    check_eq("inv10_ok", bus.inv_ok, 1'b1);

    run_op("even", 4, 8, 0, lat);
    check_eq("even_lat", lat, 2);
    check_eq("even_out", bus.inv_out, 0);
    check_eq("even_ok", bus.inv_ok, 1'b0);

    run_op("a0", 0, 7, 0, lat);
    check_eq("a0_lat", lat, 2);
    check_eq("a0_out", bus.inv_out, 0);
    check_eq("a0_ok", bus.inv_ok, 1'b0);

    run_op("inv3b", 3, 11, 0, lat);
    check_eq("inv3b_out", bus.inv_out, 4);

    run_op("gcd3", 6, 9, 0, lat);
    check_eq("gcd3_out", bus.inv_out, 0);
    check_eq("gcd3_ok", bus.inv_ok, 1'b0);

    run_op("inv3c", 3, 11, 0, lat);
    run_op("m1", 5, 1, 0, lat);
    check_eq("m1_lat", lat, 2);
    check_eq("m1_out", bus.inv_out, 0);
    check_eq("m1_ok", bus.inv_ok, 1'b0);

    run_op("ign", 17, 3120, 5, lat);
    check_eq("ign_out", bus.inv_out, 2753);
    check_eq("ign_ok", bus.inv_ok, 1'b1);
    count_done(60, cnt);
    check_eq("ign_extra_done", cnt, 0);

    // Abort a computation that is in RUN.
    @(negedge aclk);
    bus.start = 1'b1;
    bus.a_in  = W'(17);
    bus.m_in  = W'(3120);
    @(negedge aclk);
    bus.start = 1'b0;
    repeat (5) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_done", bus.done, 1'b0);
    check_eq("abort_out", bus.inv_out, 0);
    check_eq("abort_ok", bus.inv_ok, 1'b0);
    count_done(80, cnt);
    check_eq("abort_no_done", cnt, 0);

    run_op("post", 3, 11, 0, lat);
    check_eq("post_out", bus.inv_out, 4);
    check_eq("post_ok", bus.inv_ok, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_inverse.md
Name: mod_inverse

Overview:
- Sequential modular-inverse engine; the key-generation counterpart of the team's modular exponentiation core.
- Computes inv_out = a_in^-1 mod m_in, e.g. private exponent d = e^-1 mod phi, using the extended binary GCD (HAC 14.61).
- Performs one shift/subtract step per clock.
- Feeds d and related constants to the mod-power datapath through a start/done handshake.

Parameters:
- WIDTH, 512, operand and result width in bits.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request; operands sampled on the same edge; ignored while busy=1.
- a_in  input  WIDTH  value to invert, unsigned.
- m_in  input  WIDTH  modulus, unsigned.
- busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  output  1  one-cycle pulse; inv_out and inv_ok are valid from this cycle.
- inv_out  output  WIDTH  inverse in [0, m_in-1]; 0 when inv_ok=0.
- inv_ok  output  1  1 = gcd(a,m)=1 and the inverse exists.

Behaviour:
- Reset (aresetn=0 at a posedge): state=IDLE, busy=0, done=0, inv_out=0, inv_ok=0. Reset mid-operation aborts the computation with no done pulse.
- States: IDLE, CHECK, RUN, NORM, DONE.
- IDLE, start=1:
  - Latch x=a_in, y=m_in, u=a_in, v=m_in, A=1, B=0, C=0, D=1.
  - Go to CHECK.
- CHECK, one cycle:
  - If x==0, y<2, or x and y both even: inv_out=0, inv_ok=0, go to DONE.
  - Otherwise go to RUN.
- RUN performs exactly one step per cycle, chosen in priority order:
  - (1) u==0: go to NORM.
  - (2) u even: u=u>>1. If A and B are both even, A=A>>>1 and B=B>>>1. Otherwise A=(A+y)>>>1 and B=(B-x)>>>1.
  - (3) v even: same as (2) applied to v, C, D.
  - (4) u>=v: u=u-v, A=A-C, B=B-D.
  - (5) otherwise: v=v-u, C=C-A, D=D-B.
- Arithmetic and widths:
  - u and v are unsigned WIDTH bits.
  - A, B, C, D are two's-complement WIDTH+2 bits.
  - Sums before the halving shift are computed at WIDTH+3 bits so no overflow is possible.
  - >>> is an arithmetic shift.
- NORM:
  - If v!=1: inv_ok=0, inv_out=0, go to DONE.
  - Otherwise, one correction per cycle: if C<0, C=C+y; else if C>=y, C=C-y; else inv_out=C[WIDTH-1:0], inv_ok=1, go to DONE.
- DONE, one cycle: done=1, busy=0, return to IDLE.
  - start may be accepted in the first IDLE cycle after DONE.
  - inv_out and inv_ok hold their values until the next done.
- Latency:
  - Start to done is at most 4*WIDTH+8 cycles for any legal operands.
  - CHECK errors produce done exactly 2 cycles after the start edge.
- start while busy=1 (in CHECK, RUN or NORM) is ignored; latched operands are unaffected.
- Operand ordering: a_in>=m_in is legal, and the result is reduced into [0, m_in-1]. m_in need not be prime or odd, provided a_in is odd when m_in is even.

Test Plan:
- a_in=17, m_in=3120, start pulse: done within 4*WIDTH+8 cycles, inv_out=2753, inv_ok=1, a single done pulse.
- a_in=3, m_in=11: inv_out=4, inv_ok=1. Then a_in=10, m_in=11: inv_out=10, inv_ok=1. Issue the two back-to-back, the second start in the cycle after done.
- a_in=6, m_in=9 (gcd 3): done with inv_ok=0, inv_out=0. a_in=4, m_in=8: done exactly 2 cycles after start, inv_ok=0.
- a_in=0, m_in=7, and a_in=5, m_in=1: early done with inv_ok=0, inv_out=0.
- Pulse start with a_in=2, m_in=5 while busy from a_in=17, m_in=3120: the second request is ignored, and the result is 2753 with exactly one done pulse.
- Drive aresetn=0 for one cycle mid-RUN: busy=0, done=0, inv_out=0 next cycle, and no done pulse follows. A new start then with a_in=3, m_in=11 yields 4.
